// File: rtl/encoder_counter_if.sv
// Snapshot readout handshake between the position accumulator and its consumer.
// The readout side drives the request and acknowledge; the accumulator returns the captured data.
interface encoder_counter_if #(
   parameter int ANG_W  = 13,
   parameter int TURN_W = 16,
   parameter int TS_W   = 32
);
   logic              snap_req;
   logic              snap_ack;
   logic              snap_valid;
   logic [ANG_W-1:0]  snap_angle;
   logic [TURN_W-1:0] snap_turns;
   logic [TS_W-1:0]   snap_ts;

   modport master (
      output snap_req, snap_ack,
      input  snap_valid, snap_angle, snap_turns, snap_ts
   );

   modport slave (
      input  snap_req, snap_ack,
      output snap_valid, snap_angle, snap_turns, snap_ts
   );
endinterface

// File: rtl/encoder_counter.sv
// Quadrature position accumulator: angle modulo CPR plus a signed turn count.
// The angle is re-zeroed on the index pulse, and a timestamped snapshot is offered over valid/ack.
module encoder_counter #(
   parameter int CPR    = 8192,
   parameter int ANG_W  = 13,
   parameter int TURN_W = 16,
   parameter int TS_W   = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          step,
   input  logic                z_in,
   input  logic                clr,
   output logic [ANG_W-1:0]    angle,
   output logic [TURN_W-1:0]   turns,
   output logic                homed,
   output logic                err,
   output logic                ovr,
   encoder_counter_if.slave    snap
);
   localparam logic [ANG_W-1:0] ANG_MAX = ANG_W'(CPR - 1);

   logic [TS_W-1:0]   ts;
   logic              z_meta, z_sync, z_prev;
   logic              z_edge;
   logic [ANG_W-1:0]  angle_nxt;
   logic [TURN_W-1:0] turns_nxt;
   logic              capture;

   assign z_edge  = z_sync & ~z_prev;
   // A request is accepted while empty, or when the held data is acknowledged in the same cycle.
   assign capture = snap.snap_req & (~snap.snap_valid | snap.snap_ack);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z_meta <= 1'b0;
         z_sync <= 1'b0;
         z_prev <= 1'b0;
      end else begin
         z_meta <= z_in;
         z_sync <= z_meta;
         z_prev <= z_sync;
      end
   end

   always_comb begin
      angle_nxt = angle;
      turns_nxt = turns;
      if (step == 2'b01) begin
         if (angle == ANG_MAX) begin
            angle_nxt = '0;
            turns_nxt = turns + TURN_W'(1);
         end else begin
            angle_nxt = angle + ANG_W'(1);
         end
      end else if (step == 2'b10) begin
         if (angle == '0) begin
            angle_nxt = ANG_MAX;
            turns_nxt = turns - TURN_W'(1);
         end else begin
            angle_nxt = angle - ANG_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts    <= '0;
         angle <= '0;
         turns <= '0;
         homed <= 1'b0;
         err   <= 1'b0;
      end else begin
         ts <= ts + TS_W'(1);
         if (clr) begin
            angle <= '0;
            turns <= '0;
            homed <= 1'b0;
            err   <= 1'b0;
         end else begin
            if (step == 2'b11) err <= 1'b1;
            if (z_edge) begin
               angle <= '0;
               homed <= 1'b1;
            end else begin
               angle <= angle_nxt;
               turns <= turns_nxt;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap.snap_valid <= 1'b0;
         snap.snap_angle <= '0;
         snap.snap_turns <= '0;
         snap.snap_ts    <= '0;
         ovr             <= 1'b0;
      end else begin
         if (capture) begin
            snap.snap_valid <= 1'b1;
            snap.snap_angle <= angle;
            snap.snap_turns <= turns;
            snap.snap_ts    <= ts;
         end else if (snap.snap_ack) begin
            snap.snap_valid <= 1'b0;
         end
         if (clr) ovr <= 1'b0;
         else if (snap.snap_req && snap.snap_valid && !snap.snap_ack) ovr <= 1'b1;
      end
   end
endmodule

// File: tb/tb_encoder_counter.sv
// Self-checking bench for encoder_counter: vector table, directed corner sequences and
// randomized traffic, all checked against a total-position reference model.
module tb_encoder_counter;
   localparam int CPR    = 8192;
   localparam int ANG_W  = 13;
   localparam int TURN_W = 16;
   localparam int TS_W   = 32;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic [1:0]        step  = 2'b00;
   logic              z_in  = 1'b0;
   logic              clr   = 1'b0;
   logic [ANG_W-1:0]  angle;
   logic [TURN_W-1:0] turns;
   logic              homed, err, ovr;

   encoder_counter_if #(.ANG_W(ANG_W), .TURN_W(TURN_W), .TS_W(TS_W)) sif ();

   encoder_counter #(.CPR(CPR), .ANG_W(ANG_W), .TURN_W(TURN_W), .TS_W(TS_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .step  (step),
      .z_in  (z_in),
      .clr   (clr),
      .angle (angle),
      .turns (turns),
      .homed (homed),
      .err   (err),
      .ovr   (ovr),
      .snap  (sif)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: position held as one unbounded signed count; angle/turns derived from it.
   longint      pos;
   bit          m_homed, m_err, m_ovr, m_sv;
   longint      m_sa, m_st;
   logic [31:0] m_sts, m_ts;
   bit          zq[$];

   function automatic longint fdiv(input longint a);
      if (a >= 0) return a / CPR;
      return -((-a + CPR - 1) / CPR);
   endfunction

   function automatic longint m_angle();
      return pos - fdiv(pos) * CPR;
   endfunction

   function automatic longint m_turns();
      return fdiv(pos) & 64'hFFFF;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      pos = 0; m_homed = 0; m_err = 0; m_ovr = 0; m_sv = 0;
      m_sa = 0; m_st = 0; m_sts = '0; m_ts = '0;
      zq = {1'b0, 1'b0, 1'b0};
   endtask

   task automatic model_edge();
      bit idx, old_sv;
      idx    = zq[$-1] && !zq[$-2];
      old_sv = m_sv;
      if (sif.snap_req && (!old_sv || sif.snap_ack)) begin
         m_sv = 1; m_sa = m_angle(); m_st = m_turns(); m_sts = m_ts;
      end else if (sif.snap_ack) begin
         m_sv = 0;
      end
      if (clr) begin
         pos = 0; m_homed = 0; m_err = 0; m_ovr = 0;
      end else begin
         if (sif.snap_req && old_sv && !sif.snap_ack) m_ovr = 1;
         if (step == 2'b11) m_err = 1;
         if (idx) begin
            pos = fdiv(pos) * CPR;
            m_homed = 1;
         end else if (step == 2'b01) pos++;
         else if (step == 2'b10) pos--;
      end
      m_ts = m_ts + 32'd1;
      zq.push_back(z_in);
      void'(zq.pop_front());
   endtask

   task automatic check_all();
      chk("angle", 64'(angle), 64'(m_angle()));
      chk("turns", 64'(turns), 64'(m_turns()));
      chk("homed", 64'(homed), 64'(m_homed));
      chk("err", 64'(err), 64'(m_err));
      chk("ovr", 64'(ovr), 64'(m_ovr));
      chk("snap_valid", 64'(sif.snap_valid), 64'(m_sv));
      chk("snap_angle", 64'(sif.snap_angle), 64'(m_sa));
      chk("snap_turns", 64'(sif.snap_turns), 64'(m_st));
      chk("snap_ts", 64'(sif.snap_ts), 64'(m_sts));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   typedef struct {
      logic [1:0] st;
      bit         c;
      int         ea;
      int         et;
      bit         ee;
   } vec_t;

   vec_t        tbl[12];
   bit          found;
   logic [31:0] tsp;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      sif.snap_req = 1'b0;
      sif.snap_ack = 1'b0;
      model_reset();
      #12;
      check_all();
      #5 rst_n = 1'b1;

      tbl[0]  = '{2'b01, 0, 1, 0, 0};
      tbl[1]  = '{2'b01, 0, 2, 0, 0};
      tbl[2]  = '{2'b01, 0, 3, 0, 0};
      tbl[3]  = '{2'b01, 0, 4, 0, 0};
      tbl[4]  = '{2'b01, 0, 5, 0, 0};
      tbl[5]  = '{2'b10, 0, 4, 0, 0};
      tbl[6]  = '{2'b10, 0, 3, 0, 0};
      tbl[7]  = '{2'b11, 0, 3, 0, 1};
      tbl[8]  = '{2'b00, 0, 3, 0, 1};
      tbl[9]  = '{2'b01, 1, 0, 0, 0};
      tbl[10] = '{2'b10, 0, 8191, 65535, 0};
      tbl[11] = '{2'b01, 0, 0, 0, 0};
      for (int i = 0; i < 12; i++) begin
         step = tbl[i].st;
         clr  = tbl[i].c;
         cyc();
         chk("vec_angle", 64'(angle), 64'(tbl[i].ea));
         chk("vec_turns", 64'(turns), 64'(tbl[i].et));
         chk("vec_err", 64'(err), 64'(tbl[i].ee));
      end
      step = 2'b00; clr = 1'b0;

      // forward/backward wrap at the revolution boundary
      clr = 1'b1; cyc(); clr = 1'b0;
      step = 2'b01;
      repeat (8191) cyc();
      chk("wrap_pre_angle", 64'(angle), 64'd8191);
      cyc();
      chk("wrap_fwd_angle", 64'(angle), 64'd0);
      chk("wrap_fwd_turns", 64'(turns), 64'd1);
      step = 2'b10; cyc();
      chk("wrap_back_angle", 64'(angle), 64'd8191);
      chk("wrap_back_turns", 64'(turns), 64'd0);
      cyc();
      chk("wrap_back2_angle", 64'(angle), 64'd8190);
      step = 2'b00;

      // index pulse while stepping
      clr = 1'b1; cyc(); clr = 1'b0;
      step = 2'b01;
      repeat (100) cyc();
      chk("idx_pre_angle", 64'(angle), 64'd100);
      z_in = 1'b1;
      found = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         if (angle == '0 && homed) begin
            found = 1;
            break;
         end
      end
      chk("idx_latency", 64'(found), 64'd1);
      chk("idx_turns", 64'(turns), 64'd0);
      cyc();
      chk("idx_resume1", 64'(angle), 64'd1);
      cyc();
      chk("idx_resume2", 64'(angle), 64'd2);
      z_in = 1'b0; step = 2'b00;

      // snapshot handshake at angle 42, turns -2
      clr = 1'b1; cyc(); clr = 1'b0;
      step = 2'b10;
      repeat (16342) cyc();
      step = 2'b00;
      chk("snap_pre_angle", 64'(angle), 64'd42);
      chk("snap_pre_turns", 64'(turns), 64'hFFFE);
      sif.snap_req = 1'b1; tsp = m_ts;
      cyc();
      sif.snap_req = 1'b0;
      chk("snap1_valid", 64'(sif.snap_valid), 64'd1);
      chk("snap1_angle", 64'(sif.snap_angle), 64'd42);
      chk("snap1_turns", 64'(sif.snap_turns), 64'hFFFE);
      chk("snap1_ts", 64'(sif.snap_ts), 64'(tsp));
      sif.snap_req = 1'b1; step = 2'b01;
      cyc();
      sif.snap_req = 1'b0; step = 2'b00;
      chk("snap_ovr", 64'(ovr), 64'd1);
      chk("snap_ovr_hold", 64'(sif.snap_angle), 64'd42);
      sif.snap_ack = 1'b1; cyc(); sif.snap_ack = 1'b0;
      chk("snap_ack_valid", 64'(sif.snap_valid), 64'd0);
      sif.snap_req = 1'b1; cyc(); sif.snap_req = 1'b0;
      step = 2'b01; cyc(); step = 2'b00;
      sif.snap_req = 1'b1; sif.snap_ack = 1'b1;
      cyc();
      sif.snap_req = 1'b0; sif.snap_ack = 1'b0;
      chk("snap_ra_valid", 64'(sif.snap_valid), 64'd1);
      chk("snap_ra_angle", 64'(sif.snap_angle), 64'd44);
      chk("snap_ra_ovr", 64'(ovr), 64'd1);

      // illegal step code, then clear
      step = 2'b11; cyc(); step = 2'b00;
      chk("ill_angle", 64'(angle), 64'd44);
      chk("ill_err", 64'(err), 64'd1);
      clr = 1'b1; cyc(); clr = 1'b0;
      chk("clr_angle", 64'(angle), 64'd0);
      chk("clr_err", 64'(err), 64'd0);
      chk("clr_ovr", 64'(ovr), 64'd0);
      chk("clr_valid", 64'(sif.snap_valid), 64'd1);

      // asynchronous reset between edges with a snapshot pending
      step = 2'b01;
      repeat (3) cyc();
      #3 rst_n = 1'b0;
      #1;
      chk("arst_angle", 64'(angle), 64'd0);
      chk("arst_turns", 64'(turns), 64'd0);
      chk("arst_homed", 64'(homed), 64'd0);
      chk("arst_valid", 64'(sif.snap_valid), 64'd0);
      chk("arst_snap_angle", 64'(sif.snap_angle), 64'd0);
      chk("arst_snap_ts", 64'(sif.snap_ts), 64'd0);
      model_reset();
      #2 rst_n = 1'b1;
      cyc();
      cyc();
      chk("arst_resume", 64'(angle), 64'd2);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 31) == 0) step = 2'b11;
         else step = 2'($urandom_range(0, 2));
         clr = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 15) == 0) z_in = ~z_in;
         sif.snap_req = ($urandom_range(0, 7) == 0);
         sif.snap_ack = ($urandom_range(0, 3) == 0);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/encoder_counter.md
# encoder_counter

Position accumulator directly downstream of the quadrature step decoder. It consumes the registered 2-bit step code (01 = one count forward, 10 = one count backward, 00 = idle) and maintains an angle count modulo one revolution plus a signed turn counter. It re-zeroes the angle on the index (Z) pulse and offers a timestamped snapshot of {turns, angle} to the readout logic over a valid/ack handshake.

## Interface
Parameters:
- CPR, 8192: counts per revolution; angle range 0..CPR-1; must be ≥ 2.
- ANG_W, 13: angle width; must satisfy 2^ANG_W ≥ CPR.
- TURN_W, 16: signed turn counter width, two's complement.
- TS_W, 32: free-running timestamp width.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- step  in  2  step code from decoder, synchronous to clk; 01 up, 10 down, 00 idle, 11 illegal.
- z_in  in  1  raw index signal, asynchronous.
- clr  in  1  synchronous clear: angle, turns, homed, err, ovr ← 0.
- angle  out  ANG_W  current angle count.
- turns  out  TURN_W  current signed revolution count.
- homed  out  1  set on the first index edge after reset/clr.
- err  out  1  sticky: an illegal step code was seen.
- snap_req  in  1  single-cycle request to capture a snapshot.
- snap_valid  out  1  snapshot registers hold unread data.
- snap_ack  in  1  consumer accepts the snapshot.
- snap_angle  out  ANG_W  captured angle.
- snap_turns  out  TURN_W  captured turns.
- snap_ts  out  TS_W  timestamp at capture.
- ovr  out  1  sticky: a snap_req was dropped because snap_valid was high.

## Operation
- Reset (async, rst_n=0): all outputs 0, including angle, turns, homed, err, ovr, snap_valid, snap_*, and the timestamp.
- Timestamp: increments by 1 every cycle and wraps at 2^TS_W; unaffected by clr.
- Step processing, evaluated each edge:
  - 01 with angle=CPR-1: angle←0 and turns←turns+1. Otherwise 01: angle+1.
  - 10 with angle=0: angle←CPR-1 and turns←turns-1. Otherwise 10: angle-1.
  - 00: hold.
  - 11: hold and set err.
- turns wraps silently in two's complement (0x7FFF+1 → 0x8000 for TURN_W=16).
- Index handling:
  - z_in passes through a 2-FF synchronizer, then rising-edge detection on the synchronized signal.
  - On a detected edge: angle←0 and homed←1; turns unchanged.
  - A step in the same cycle is discarded, so the index wins.
  - A step code of 11 still sets err.
- Priority, highest first: clr, then index edge, then step. clr in the same cycle as an index edge leaves homed=0.
- Snapshot handshake:
  - snap_req while snap_valid=0 captures angle/turns/ts as they stand before this edge, i.e. excluding the step sampled in this cycle. snap_valid←1.
  - snap_req while snap_valid=1 with no ack in the same cycle: the request is dropped, ovr←1, and the held data is unchanged.
  - snap_ack while snap_valid=1: snap_valid←0. An ack with snap_valid=0 is ignored.
  - snap_req and snap_ack in the same cycle while valid: the new capture is taken and snap_valid stays 1; no overrun.
  - clr does not touch snap_valid or snap_* data; it clears ovr.

## Timing
- Step latency: step sampled at edge N is reflected in angle/turns after edge N (1 cycle). Total from encoder pins is decoder latency + 1.
- Index latency: z_in rising is reflected in angle=0 at most 3 edges after it is sampled high (2 synchronizer stages + edge-detect register).
- Snapshot: snap_valid is high after the edge that sampled snap_req. snap_ts equals the timestamp value before that edge.
- Throughput: one step per cycle sustained. The decoder cannot emit more than one step per cycle.
- clr takes effect on the edge that samples it.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Reset, then 5 cycles of step=01, then 2 of step=10 → angle=3, turns=0, err=0.
- Forward wrap: with CPR=8192, drive angle to 8191 and apply one step=01 → angle=0, turns=1. Then one step=10 → angle=8191, turns=0. Then one more step=10 → angle=8190, turns=0. From angle=0, turns=0, one step=10 → angle=8191, turns=-1 (0xFFFF).
- Index: drive angle to 100 and raise z_in while applying step=01 every cycle → within 3 cycles of z_in high, angle=0 and homed=1, with turns unchanged. Counting resumes 1, 2, … on subsequent steps.
- Snapshot handshake: at angle=42, turns=-2, pulse snap_req → snap_valid=1, snap_angle=42, snap_turns=0xFFFE, snap_ts=request-cycle timestamp. Pulse snap_req again without ack → ovr=1, data still 42. Assert snap_ack → snap_valid=0. Assert req+ack together while valid → new data, snap_valid stays 1, ovr unchanged.
- Illegal code and clr: apply step=11 for one cycle → angle unchanged, err=1. Pulse clr → angle=0, turns=0, homed=0, err=0, ovr=0, snap_valid retained.
- Asynchronous reset mid-operation: drop rst_n between edges during counting with a snapshot pending → all outputs 0 immediately, without waiting for a clock edge. After release, the counter resumes from 0.
